// File: rtl/double_adder_arbiter_pkg.sv
// Shared types and constants for the round-robin double-precision adder arbiter.
package dadd_arb_pkg;

    localparam int DW = 64;
    localparam logic [DW-1:0] DADD_QNAN = 64'h7FF8000000000000;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_Z,
        ZACK,
        RETURN
    } arb_state_e;

endpackage

// File: rtl/double_adder_arbiter_if.sv
// Requester and adder-side bus of the arbiter; master is the arbiter's view, slave the surroundings.
// rsp_err exists only when DADD_ARB_TIMEOUT_EN is defined.
interface dadd_arb_if
    import dadd_arb_pkg::*;
#(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [DW*NREQ-1:0] req_a;
    logic [DW*NREQ-1:0] req_b;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_z;
    logic [NREQ-1:0]    rsp_ack;
`ifdef DADD_ARB_TIMEOUT_EN
    logic               rsp_err;
`endif
    logic [DW-1:0]      add_a;
    logic [DW-1:0]      add_b;
    logic               add_a_stb;
    logic               add_b_stb;
    logic               add_a_ack;
    logic               add_b_ack;
    logic [DW-1:0]      add_z;
    logic               add_z_stb;
    logic               add_z_ack;

    modport master (
        input  req_valid, req_a, req_b, rsp_ack,
        input  add_a_ack, add_b_ack, add_z, add_z_stb,
        output req_ready, rsp_valid, rsp_z,
`ifdef DADD_ARB_TIMEOUT_EN
        output rsp_err,
`endif
        output add_a, add_b, add_a_stb, add_b_stb, add_z_ack
    );

    modport slave (
        output req_valid, req_a, req_b, rsp_ack,
        output add_a_ack, add_b_ack, add_z, add_z_stb,
        input  req_ready, rsp_valid, rsp_z,
`ifdef DADD_ARB_TIMEOUT_EN
        input  rsp_err,
`endif
        input  add_a, add_b, add_a_stb, add_b_stb, add_z_ack
    );

endinterface

// File: rtl/double_adder_arbiter_rr_arbiter.sv
// Combinational round-robin select: first set request bit searching upward from ptr+1, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   index_o,
    output logic            any_o
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        index_o = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(ptr_i) + k) % NREQ);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                index_o     = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/double_adder_arbiter.sv
// Shares one double-precision adder between NREQ requesters, one operation in flight, round-robin.
// Optional watchdog returning a quiet NaN with rsp_err: define DADD_ARB_TIMEOUT_EN.
module double_adder_arbiter
    import dadd_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst,
    dadd_arb_if.master bus
);

    localparam int              IW      = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE     = NREQ'(1);
    localparam logic [IW-1:0]   PTR_RST = IW'(NREQ - 1);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("double_adder_arbiter: NREQ must be 2..8 and TIMEOUT positive");
    end

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [DW-1:0]   add_a_q, add_a_d;
    logic [DW-1:0]   add_b_q, add_b_d;
    logic            a_stb_q, a_stb_d;
    logic            b_stb_q, b_stb_d;
    logic            z_ack_q, z_ack_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_z_q, rsp_z_d;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;

`ifdef DADD_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT >= 1024) ? $clog2(TIMEOUT + 1) : 10;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timed_out;
`endif

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .index_o (gnt_idx),
        .any_o   (gnt_any)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        a_stb_d     = a_stb_q;
        b_stb_d     = b_stb_q;
        z_ack_d     = 1'b0;
        req_ready_d = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_z_d     = rsp_z_q;
`ifdef DADD_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
        timed_out   = (cnt_q == CNT_W'(TIMEOUT));
`endif
        unique case (state_q)
            IDLE: begin
`ifdef DADD_ARB_TIMEOUT_EN
                // A result arriving after its operation timed out is acked and dropped here.
                z_ack_d = bus.add_z_stb;
`endif
                if (gnt_any) begin
                    gidx_d      = gnt_idx;
                    add_a_d     = bus.req_a[gnt_idx*DW +: DW];
                    add_b_d     = bus.req_b[gnt_idx*DW +: DW];
                    a_stb_d     = 1'b1;
                    b_stb_d     = 1'b1;
                    req_ready_d = gnt;
                    state_d     = ISSUE;
`ifdef DADD_ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            ISSUE: begin
                if (a_stb_q && bus.add_a_ack) a_stb_d = 1'b0;
                if (b_stb_q && bus.add_b_ack) b_stb_d = 1'b0;
                if (!a_stb_d && !b_stb_d) state_d = WAIT_Z;
`ifdef DADD_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
            end
            WAIT_Z: begin
                if (bus.add_z_stb) begin
                    rsp_z_d = bus.add_z;
                    z_ack_d = 1'b1;
                    state_d = ZACK;
                end
`ifdef DADD_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
            end
            ZACK: begin
                if (bus.add_z_stb) begin
                    z_ack_d = 1'b1;
                end else begin
                    rsp_valid_d = ONE << gidx_q;
                    state_d     = RETURN;
                end
            end
            RETURN: begin
                if (bus.rsp_ack[gidx_q]) begin
                    rsp_valid_d = '0;
                    ptr_d       = gidx_q;
                    state_d     = IDLE;
`ifdef DADD_ARB_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef DADD_ARB_TIMEOUT_EN
        if ((state_q == ISSUE || state_q == WAIT_Z) && timed_out) begin
            a_stb_d     = 1'b0;
            b_stb_d     = 1'b0;
            z_ack_d     = 1'b0;
            rsp_z_d     = DADD_QNAN;
            rsp_valid_d = ONE << gidx_q;
            err_d       = 1'b1;
            state_d     = RETURN;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= PTR_RST;
            gidx_q      <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            a_stb_q     <= 1'b0;
            b_stb_q     <= 1'b0;
            z_ack_q     <= 1'b0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_z_q     <= '0;
`ifdef DADD_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            a_stb_q     <= a_stb_d;
            b_stb_q     <= b_stb_d;
            z_ack_q     <= z_ack_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_z_q     <= rsp_z_d;
`ifdef DADD_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_z     = rsp_z_q;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.add_a_stb = a_stb_q;
    assign bus.add_b_stb = b_stb_q;
    assign bus.add_z_ack = z_ack_q;
`ifdef DADD_ARB_TIMEOUT_EN
    assign bus.rsp_err   = err_q;
`endif

endmodule

// File: tb/tb_double_adder_arbiter.sv
// Randomized scoreboard bench for double_adder_arbiter with a behavioural stb/ack adder model.
`timescale 1ns/1ps
module tb_double_adder_arbiter;
    import dadd_arb_pkg::*;

    localparam int N  = 4;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dadd_arb_if #(.NREQ(N)) bus ();

    double_adder_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          idx;
        logic [63:0] z;
        bit          err;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t        sb_q[$];
    int          grants[$];
    logic [N-1:0] m_valid;
    logic [63:0] m_a [N];
    logic [63:0] m_b [N];
    int          m_ptr;
    int          mode;
    bit          expect_to;

    // adder model knobs and state
    int          a_lat, b_lat, z_lat;
    bit          z_never;
    bit          a_got, b_got;
    int          a_w, b_w, z_w;
    logic [63:0] a_val, b_val;
    int          issues = 0;

    // monitor state
    int          stall_owner = -1;
    int          stall_len   = 0;
    int          rsp_count   = 0;
    int          last_owner  = -1;
    logic [63:0] last_z;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] fadd(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) + $bitstoreal(b));
    endfunction

    function automatic int rr_model(input int ptr, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Behavioural adder: one-cycle ack pulses after a per-operand latency, result held until acked.
    always @(posedge clk) begin
        if (rst) begin
            bus.add_a_ack <= 1'b0;
            bus.add_b_ack <= 1'b0;
            bus.add_z_stb <= 1'b0;
            bus.add_z     <= '0;
            a_got = 0; b_got = 0; a_w = 0; b_w = 0; z_w = 0;
        end else begin
            if (bus.add_a_ack) begin
                bus.add_a_ack <= 1'b0;
                chk("add_a_stable", bus.add_a, a_val);
            end else if (a_got) begin
                chk("a_stb_after_ack", bus.add_a_stb, 0);
            end else if (bus.add_a_stb) begin
                if (a_w >= a_lat) begin bus.add_a_ack <= 1'b1; a_got = 1; a_val = bus.add_a; end
                else a_w++;
            end
            if (bus.add_b_ack) begin
                bus.add_b_ack <= 1'b0;
                chk("add_b_stable", bus.add_b, b_val);
            end else if (b_got) begin
                chk("b_stb_after_ack", bus.add_b_stb, 0);
            end else if (bus.add_b_stb) begin
                if (b_w >= b_lat) begin bus.add_b_ack <= 1'b1; b_got = 1; b_val = bus.add_b; end
                else b_w++;
            end
            if (bus.add_z_stb) begin
                if (bus.add_z_ack) begin
                    bus.add_z_stb <= 1'b0;
                    a_got = 0; b_got = 0; a_w = 0; b_w = 0; z_w = 0;
                    issues++;
                end
            end else if (a_got && b_got && !bus.add_a_ack && !bus.add_b_ack && !z_never) begin
                if (z_w >= z_lat) begin
                    bus.add_z_stb <= 1'b1;
                    bus.add_z     <= fadd(a_val, b_val);
                end else z_w++;
            end
        end
    end

    // Monitor: pops the scoreboard whenever a result is presented, then acks it.
    exp_t        mon_e;
    int          mon_stall;
    logic [N-1:0] mon_oh;
    logic [63:0] mon_z0;
    always begin
        @(negedge clk);
        if (!rst && bus.rsp_valid !== '0) begin
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", bus.rsp_valid, 0);
            end else begin
                mon_e  = sb_q.pop_front();
                mon_oh = N'(1) << mon_e.idx;
                chk("rsp_valid_owner", bus.rsp_valid, mon_oh);
                chk("rsp_z", bus.rsp_z, mon_e.z);
`ifdef DADD_ARB_TIMEOUT_EN
                chk("rsp_err", bus.rsp_err, mon_e.err);
`endif
                mon_z0     = bus.rsp_z;
                last_z     = bus.rsp_z;
                last_owner = mon_e.idx;
                rsp_count++;
                mon_stall  = (stall_owner == mon_e.idx) ? stall_len : $urandom_range(0, 2);
                for (int s = 0; s < mon_stall; s++) begin
                    bus.rsp_ack = N'($urandom) & ~mon_oh;
                    @(negedge clk);
                    chk("rsp_z_hold", bus.rsp_z, mon_z0);
                    chk("rsp_valid_hold", bus.rsp_valid, mon_oh);
                    if (stall_owner == mon_e.idx) begin
                        chk("stall_a_stb", bus.add_a_stb, 0);
                        chk("stall_req_ready", bus.req_ready, 0);
                    end
                end
                bus.rsp_ack = mon_oh;
                @(negedge clk);
                bus.rsp_ack = '0;
                chk("rsp_valid_clear", bus.rsp_valid, 0);
            end
        end
    end

    task automatic drive();
        bus.req_valid = m_valid;
        for (int i = 0; i < N; i++) begin
            bus.req_a[64*i +: 64] = m_a[i];
            bus.req_b[64*i +: 64] = m_b[i];
        end
    endtask

    task automatic new_op(input int i);
        m_a[i]     = $realtobits(real'(i + 1));
        m_b[i]     = $realtobits(real'($urandom_range(0, 400)) / 8.0);
        m_valid[i] = 1'b1;
    endtask

    task automatic tick();
        int g;
        @(negedge clk);
        if (bus.req_ready !== '0) begin
            g = rr_model(m_ptr, m_valid);
            chk("req_ready_grant", bus.req_ready, (g < 0) ? 64'd0 : (64'd1 << g));
            if (g >= 0) begin
                sb_q.push_back('{idx: g, z: expect_to ? DADD_QNAN : fadd(m_a[g], m_b[g]), err: expect_to});
                m_ptr      = g;
                m_valid[g] = 1'b0;
                grants.push_back(g);
                if (mode == 1) begin
                    a_lat = $urandom_range(0, 2);
                    b_lat = $urandom_range(0, 2);
                    z_lat = $urandom_range(0, 4);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (mode == 2 && !m_valid[i]) new_op(i);
            else if (mode == 1) begin
                if (!m_valid[i] && $urandom_range(0, 3) == 0) new_op(i);
                else if (m_valid[i] && $urandom_range(0, 15) == 0) m_valid[i] = 1'b0;
            end
        end
        drive();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_z"}, bus.rsp_z, 0);
        chk({tag, "_add_a"}, bus.add_a, 0);
        chk({tag, "_add_b"}, bus.add_b, 0);
        chk({tag, "_add_a_stb"}, bus.add_a_stb, 0);
        chk({tag, "_add_b_stb"}, bus.add_b_stb, 0);
        chk({tag, "_add_z_ack"}, bus.add_z_ack, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_valid = '0;
        drive();
        repeat (2) @(negedge clk);
        sb_q.delete();
        grants.delete();
        m_ptr = N - 1;
        rst = 1'b0;
    endtask

    task automatic wait_grant(input string tag);
        int n0, n;
        n0 = grants.size();
        n  = 0;
        while (grants.size() == n0 && n < 100) begin tick(); n++; end
        chk({tag, "_grant_seen"}, grants.size() != n0, 1);
    endtask

    task automatic drain(input string tag, input int max);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || m_valid != '0 || bus.rsp_valid != '0 || bus.rsp_ack != '0) && n < max) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, n < max, 1);
    endtask

    initial begin
        int rc0, is0, n;
        bit skew_seen;
        rst = 1'b1;
        bus.rsp_ack = '0;
        m_valid = '0;
        for (int i = 0; i < N; i++) begin m_a[i] = '0; m_b[i] = '0; end
        drive();
        mode = 0; expect_to = 0; z_never = 0;
        a_lat = 0; b_lat = 0; z_lat = 3;
        m_ptr = N - 1;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst = 1'b0;

        // single request, 3-cycle adder
        m_a[0] = 64'h3FF0000000000000;
        m_b[0] = 64'h4000000000000000;
        m_valid = 4'b0001;
        drive();
        rc0 = rsp_count;
        wait_grant("single");
        drain("single", 100);
        chk("single_one_ready", grants.size(), 1);
        chk("single_owner", last_owner, 0);
        chk("single_z", last_z, 64'h4008000000000000);
        chk("single_rsp_count", rsp_count - rc0, 1);

        // all four continuously valid: strict rotation
        do_reset();
        mode = 2;
        n = 0;
        while (grants.size() < 16 && n < 2000) begin tick(); n++; end
        mode = 0;
        drain("fair", 500);
        chk("fair_16_ops", grants.size() >= 16, 1);
        for (int k = 0; k < 16 && k < grants.size(); k++)
            chk($sformatf("fair_order_%0d", k), grants[k], k % N);

        // skewed operand acks
        do_reset();
        a_lat = 1; b_lat = 4; z_lat = 2;
        is0 = issues;
        rc0 = rsp_count;
        new_op(3);
        drive();
        wait_grant("skew");
        skew_seen = 0;
        n = 0;
        while ((sb_q.size() != 0 || bus.rsp_valid != '0) && n < 100) begin
            if (!bus.add_a_stb && bus.add_b_stb) skew_seen = 1;
            tick();
            n++;
        end
        drain("skew", 50);
        chk("skew_independent_stb", skew_seen, 1);
        chk("skew_one_issue", issues - is0, 1);
        chk("skew_one_result", rsp_count - rc0, 1);
        a_lat = 0; b_lat = 0; z_lat = 3;

        // requester 2 withholds its ack while others wait
        do_reset();
        stall_owner = 2;
        stall_len   = 20;
        new_op(2);
        drive();
        wait_grant("stall");
        new_op(0);
        new_op(1);
        drive();
        drain("stall", 300);
        stall_owner = -1;

        // reset while waiting for the result
        do_reset();
        z_lat = 10;
        new_op(0);
        drive();
        wait_grant("rstmid");
        n = 0;
        while ((bus.add_a_stb || bus.add_b_stb) && n < 50) begin tick(); n++; end
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_reset("rstmid");
        sb_q.delete();
        grants.delete();
        m_ptr = N - 1;
        rst = 1'b0;
        z_lat = 3;
        rc0 = rsp_count;
        new_op(1);
        drive();
        wait_grant("rstmid_after");
        drain("rstmid_after", 100);
        chk("rstmid_owner", last_owner, 1);
        chk("rstmid_z", last_z, fadd(m_a[1], m_b[1]));
        chk("rstmid_rsp_count", rsp_count - rc0, 1);

        // randomized traffic with requests appearing and withdrawing
        do_reset();
        mode = 1;
        repeat (400) tick();
        mode = 0;
        drain("random", 1000);

`ifdef DADD_ARB_TIMEOUT_EN
        // adder never answers: watchdog result
        do_reset();
        z_never   = 1;
        expect_to = 1;
        new_op(0);
        drive();
        wait_grant("timeout");
        n = 0;
        while (bus.rsp_valid == '0 && n < 40) begin tick(); n++; end
        chk("timeout_latency", n, TO + 1);
        chk("timeout_err", bus.rsp_err, 1);
        chk("timeout_qnan", bus.rsp_z, 64'h7FF8000000000000);
        drain("timeout", 50);
        expect_to = 0;
        z_never   = 0;
        do_reset();
`endif

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/double_adder_arbiter.md
Name: double_adder_arbiter

Overview:
- Shares one `double_addadder` instance (IEEE-754 double, stb/ack handshakes) between NREQ requesters.
- Round-robin grant; one operation in flight at a time.
- Owns the adder's input and output handshakes and returns each result only to the requester that issued it.
- Sits between the requesters and the single adder datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 1023, watchdog limit in cycles; used only with DADD_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i has an operand pair pending.
- req_a  in  64*NREQ  operand A per requester; slice i = [64*i+63:64*i].
- req_b  in  64*NREQ  operand B per requester; same slicing.
- req_ready  out  NREQ  one-cycle pulse: requester i's operands latched.
- rsp_valid  out  NREQ  result available for requester i (one-hot or zero).
- rsp_z  out  64  result bits, valid while any rsp_valid bit is high.
- rsp_ack  in  NREQ  requester i consumes its result.
- add_a, add_b  out  64 each  operands to adder input_a/input_b.
- add_a_stb, add_b_stb  out  1 each  to adder input_a_stb/input_b_stb.
- add_a_ack, add_b_ack  in  1 each  from adder input_a_ack/input_b_ack.
- add_z  in  64  adder output_z.
- add_z_stb  in  1  adder output_z_stb.
- add_z_ack  out  1  to adder output_z_ack.

Behaviour:
- All outputs registered.
- Reset values: req_ready=0, rsp_valid=0, rsp_z=0, add_a=add_b=0, add_*_stb=0, add_z_ack=0, state=IDLE, rr pointer=NREQ-1.
- Reset mid-operation aborts everything; the in-flight result is discarded.
- FSM states: IDLE, ISSUE, WAIT_Z, ZACK, RETURN.
- IDLE:
  - If any req_valid is high, grant g = first set bit searching upward from pointer+1 (mod NREQ).
  - Latch req_a[g] and req_b[g] into add_a/add_b.
  - Pulse req_ready[g] for exactly 1 cycle and set both stb high; go to ISSUE.
  - No req_valid: stay in IDLE.
- ISSUE:
  - add_a_stb drops the cycle after add_a_ack is sampled high; add_b_stb likewise, independently.
  - Acks may arrive in the same or different cycles.
  - Once both acks are seen, go to WAIT_Z.
  - add_a/add_b stay stable while the matching stb is high.
- WAIT_Z:
  - add_z_ack held 0.
  - On add_z_stb=1, capture add_z into rsp_z and go to ZACK.
- ZACK:
  - add_z_ack=1 until add_z_stb is sampled 0, then add_z_ack=0.
  - Set rsp_valid[g]=1; go to RETURN.
- RETURN:
  - rsp_valid[g] and rsp_z held until rsp_ack[g]=1.
  - On that cycle: rsp_valid=0, pointer=g, go to IDLE.
  - rsp_ack bits for other indices are ignored.
- Fairness: a requester that keeps req_valid high waits at most NREQ-1 other operations.
- req_valid may drop without ready; requests are never queued or buffered.
- The arbiter never inspects or modifies the result bits (NaN/Inf pass through unchanged).
- Minimum turnaround, excluding adder latency: IDLE to next IDLE is 5 cycles with immediate acks.

Optional Feature:
- Macro: DADD_ARB_TIMEOUT_EN.
- When defined:
  - A 10+ bit counter clears on entry to ISSUE and increments in ISSUE/WAIT_Z.
  - When it reaches TIMEOUT: drop both stb, set rsp_z=64'h7FF8000000000000 (quiet NaN), go to RETURN.
  - Extra output rsp_err (1 bit) is high with rsp_valid for a timed-out result.
  - A late add_z_stb is then acked and discarded in IDLE.
- When undefined:
  - No counter and no rsp_err port.
  - The arbiter waits forever for acks and results.

Decomposition:
- Package dadd_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT_Z, ZACK, RETURN);
  - DADD_QNAN = 64'h7FF8000000000000;
  - DW = 64.
- Sub-module rr_arbiter (params NREQ; inputs req, ptr; outputs one-hot gnt, index, any): purely combinational round-robin priority select, instantiated once.

Test Plan:
- Single request: req_valid=0001, a=3FF0000000000000, b=4000000000000000, adder model with 3-cycle latency -> req_ready[0] pulses once, rsp_valid=0001, rsp_z=4008000000000000, held until rsp_ack[0].
- All four valid continuously, operands a=i+1.0 -> grant order 0,1,2,3,0; each rsp_valid bit matches the owning requester; no starvation over 16 ops.
- Skewed acks: model returns add_a_ack 1 cycle and add_b_ack 4 cycles after stb -> each stb drops independently; no duplicate issue; one result returned.
- Requester stalls: rsp_ack[2] withheld 20 cycles -> rsp_z stable, add_a_stb stays 0, req_ready stays 0 for all requesters.
- rst asserted during WAIT_Z -> next cycle all outputs at reset values; after release, a fresh request to requester 1 completes normally.
- With DADD_ARB_TIMEOUT_EN, TIMEOUT=15, model never raises add_z_stb -> rsp_valid and rsp_err high 16 cycles after ISSUE entry, rsp_z=7FF8000000000000.
